// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive buffer: byte width, default depth
// and the capture handshake state encoding.
package uart_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned DEPTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } cap_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read port and occupancy counter.
// Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_valid,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q;
  logic             push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // push alongside it; an empty FIFO never forwards the incoming byte.
  assign pop  = rd_en && !empty;
  assign push = wr_en && (!full || pop);

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop) begin
      rptr_d    = rptr_q + 1'b1;
      rd_data_d = mem_q[rptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= pop;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures each byte once from a level-held ready
// handshake, acknowledges it, and queues it for the CPU with overrun tracking.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BYTE_W-1:0]       rx_data,
  input  logic                    rx_data_ready,
  output logic                    rx_data_ack,
  input  logic                    rd_en,
  output logic [BYTE_W-1:0]       rd_data,
  output logic                    rd_valid,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full,
  output logic                    overrun,
  input  logic                    clear_overrun
);

  cap_state_e state_q, state_d;
  logic       push_req;
  logic       ack;
  logic       drop;
  logic       overrun_q, overrun_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (rx_data_ready) state_d = ACK;
      ACK:      state_d = WAIT_LOW;
      WAIT_LOW: if (!rx_data_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Capture only from IDLE, so a ready held high across ACK/WAIT_LOW never
  // produces a second push of the same byte.
  always_comb begin
    push_req = 1'b0;
    ack      = 1'b0;
    case (state_q)
      IDLE:    push_req = rx_data_ready;
      ACK:     ack      = 1'b1;
      default: ;
    endcase
  end

  assign drop = push_req && full && !rd_en;

  always_comb begin
    overrun_d = overrun_q;
    if (drop)               overrun_d = 1'b1;
    else if (clear_overrun) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overrun_q <= 1'b0;
    else       overrun_q <= overrun_d;
  end

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (push_req),
    .wr_data  (rx_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  assign rx_data_ack = ack;
  assign overrun     = overrun_q;

endmodule
